// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, fetch stall,
// fixed-latency data-miss freeze, HLT drain-to-halt, plus saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MISS_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEXMemRead,
  input  logic [3:0]       IDEXrd,
  input  logic [3:0]       IFIDrs,
  input  logic [3:0]       IFIDrt,
  input  logic             IFIDuse_rs,
  input  logic             IFIDuse_rt,
  input  logic             IFIDHLT,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_miss,
  input  logic             MEMWBHLT,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             memwb_flush,
  output logic             dmem_refill,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DSTALL, DRAIN, HALTED} state_t;

  // The detect cycle is the first frozen cycle, so DSTALL itself lasts MISS_LAT-1 cycles.
  localparam logic [3:0] MISS_LOAD = (MISS_LAT > 1) ? 4'(MISS_LAT - 2) : 4'd0;
  localparam logic       HAS_DSTALL = (MISS_LAT > 1);

  state_t     state, state_nxt;
  logic [3:0] miss_cnt, miss_cnt_nxt;
  logic       resume, resume_nxt;

  logic pc_wen_c, ifid_wen_c, ifid_flush_c, idex_wen_c, idex_flush_c;
  logic exmem_wen_c, memwb_wen_c, memwb_flush_c, refill_c, halted_c;
  logic load_use, stall_inc;

  assign load_use = IDEXMemRead && (IDEXrd != 4'd0) &&
                    ((IFIDuse_rs && (IFIDrs == IDEXrd)) || (IFIDuse_rt && (IFIDrt == IDEXrd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      miss_cnt <= 4'd0;
      resume   <= 1'b0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_cnt_nxt;
      resume   <= resume_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    miss_cnt_nxt  = miss_cnt;
    resume_nxt    = resume;
    pc_wen_c      = 1'b0;
    ifid_wen_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_wen_c    = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_wen_c   = 1'b0;
    memwb_wen_c   = 1'b0;
    memwb_flush_c = 1'b0;
    refill_c      = 1'b0;
    halted_c      = 1'b0;
    case (state)
      RUN, DRAIN: begin
        if (dmem_miss) begin
          memwb_wen_c   = 1'b1;
          memwb_flush_c = 1'b1;
          refill_c      = 1'b1;
          if (HAS_DSTALL) begin
            state_nxt    = DSTALL;
            miss_cnt_nxt = MISS_LOAD;
            resume_nxt   = (state == DRAIN);
          end
        end else begin
          ifid_wen_c  = 1'b1;
          idex_wen_c  = 1'b1;
          exmem_wen_c = 1'b1;
          memwb_wen_c = 1'b1;
          if (state == DRAIN) begin
            ifid_flush_c = 1'b1;
            if (MEMWBHLT) state_nxt = HALTED;
          end else if (load_use) begin
            ifid_wen_c   = 1'b0;
            idex_flush_c = 1'b1;
          end else if (branch_taken) begin
            pc_wen_c     = 1'b1;
            ifid_flush_c = 1'b1;
          end else if (IFIDHLT) begin
            ifid_flush_c = 1'b1;
            state_nxt    = DRAIN;
          end else if (imem_stall) begin
            ifid_flush_c = 1'b1;
          end else begin
            pc_wen_c = 1'b1;
          end
        end
      end
      DSTALL: begin
        memwb_wen_c   = 1'b1;
        memwb_flush_c = 1'b1;
        refill_c      = 1'b1;
        if (miss_cnt == 4'd0) state_nxt = resume ? DRAIN : RUN;
        else                  miss_cnt_nxt = miss_cnt - 4'd1;
      end
      HALTED: halted_c = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  assign pc_wen      = !rst && pc_wen_c;
  assign ifid_wen    = !rst && ifid_wen_c;
  assign ifid_flush  = !rst && ifid_flush_c;
  assign idex_wen    = !rst && idex_wen_c;
  assign idex_flush  = !rst && idex_flush_c;
  assign exmem_wen   = !rst && exmem_wen_c;
  assign memwb_wen   = !rst && memwb_wen_c;
  assign memwb_flush = !rst && memwb_flush_c;
  assign dmem_refill = !rst && refill_c;
  assign halted      = !rst && halted_c;

  assign stall_inc = !pc_wen_c && ((state == RUN) || (state == DSTALL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state != HALTED) && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 1'b1;
      if (stall_inc && (stall_cnt != '1))       stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued per driven
// cycle and compared at the falling edge; counters are checked at section boundaries.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mr = 0, us = 0, ut = 0, hlt = 0, br = 0, ims = 0, miss = 0, mwhlt = 0;
  logic [3:0] rd = 0, rs = 0, rt = 0;

  logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen;
  logic memwb_wen, memwb_flush, dmem_refill, halted;
  logic [15:0] cyc_cnt, stall_cnt;

  logic s_pc, s_ifw, s_iff, s_idw, s_idf, s_exw, s_mww, s_mwf, s_ref, s_hlt;
  logic [3:0] s_cyc, s_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {string tag; logic [9:0] v;} exp_t;
  exp_t sb[$];
  int exp_cyc = 0;
  int exp_stall = 0;

  // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen, memwb_flush, refill, halted}
  localparam logic [9:0] E_RUN  = 10'b1101011000;
  localparam logic [9:0] E_LU   = 10'b0001111000;
  localparam logic [9:0] E_BR   = 10'b1111011000;
  localparam logic [9:0] E_FL   = 10'b0111011000;
  localparam logic [9:0] E_MISS = 10'b0000001110;
  localparam logic [9:0] E_HALT = 10'b0000000001;

  logic [9:0] obs;
  assign obs = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen,
                memwb_wen, memwb_flush, dmem_refill, halted};

  pipe_hazard_ctrl #(.MISS_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .IDEXMemRead(mr), .IDEXrd(rd), .IFIDrs(rs), .IFIDrt(rt),
    .IFIDuse_rs(us), .IFIDuse_rt(ut), .IFIDHLT(hlt), .branch_taken(br), .imem_stall(ims),
    .dmem_miss(miss), .MEMWBHLT(mwhlt),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush), .idex_wen(idex_wen),
    .idex_flush(idex_flush), .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .memwb_flush(memwb_flush), .dmem_refill(dmem_refill), .halted(halted),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt));

  pipe_hazard_ctrl #(.MISS_LAT(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .IDEXMemRead(mr), .IDEXrd(rd), .IFIDrs(rs), .IFIDrt(rt),
    .IFIDuse_rs(us), .IFIDuse_rt(ut), .IFIDHLT(hlt), .branch_taken(br), .imem_stall(ims),
    .dmem_miss(miss), .MEMWBHLT(mwhlt),
    .pc_wen(s_pc), .ifid_wen(s_ifw), .ifid_flush(s_iff), .idex_wen(s_idw),
    .idex_flush(s_idf), .exmem_wen(s_exw), .memwb_wen(s_mww),
    .memwb_flush(s_mwf), .dmem_refill(s_ref), .halted(s_hlt),
    .cyc_cnt(s_cyc), .stall_cnt(s_stall));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, {22'd0, obs}, {22'd0, e.v});
    end
  end

  // Drive one cycle with the current inputs; st marks a cycle expected to count as a stall.
  task automatic step(input string tag, input logic [9:0] v, input bit st);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!v[0] && exp_cyc < 65535) exp_cyc++;
    if (st) exp_stall++;
  endtask

  task automatic cnt_chk(input string tag);
    chk({tag, "_cyc"}, {16'd0, cyc_cnt}, exp_cyc);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, exp_stall);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_outs", {22'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cyc = 0;
    exp_stall = 0;
    cnt_chk("post_rst");
  endtask

  task automatic clr();
    {mr, us, ut, hlt, br, ims, miss, mwhlt} = '0;
    rd = 0; rs = 0; rt = 0;
  endtask

  initial begin
    #12;
    chk("rst_outs0", {22'd0, obs}, 32'd0);
    chk("rst_cnt0", {cyc_cnt, stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("idle", E_RUN, 0);

    mr = 1; rd = 3; rs = 3; us = 1;
    step("lu_rs", E_LU, 1);
    cnt_chk("lu");
    rd = 0; rs = 0;
    step("lu_rd0", E_RUN, 0);
    rd = 5; rt = 5; us = 0; ut = 1;
    step("lu_rt", E_LU, 1);
    ut = 0;
    step("lu_rt_unused", E_RUN, 0);
    clr();

    br = 1;
    step("br", E_BR, 0);
    mr = 1; rd = 7; rs = 7; us = 1;
    step("br_lu", E_LU, 1);
    clr();
    br = 1; hlt = 1;
    step("br_hlt", E_BR, 0);
    clr();
    ims = 1;
    step("imem", E_FL, 1);
    clr();
    cnt_chk("sec1");

    // miss wins over a pending load-use, which re-evaluates afterwards
    miss = 1; mr = 1; rd = 2; rs = 2; us = 1;
    step("miss_lu0", E_MISS, 1);
    step("miss_lu1", E_MISS, 1);
    miss = 0;
    step("miss_lu2", E_MISS, 1);
    step("miss_lu3", E_MISS, 1);
    step("miss_lu_after", E_LU, 1);
    clr();
    miss = 1;
    step("miss0", E_MISS, 1);
    miss = 0;
    for (int i = 1; i < 4; i++) step("miss_n", E_MISS, 1);
    step("miss_resume", E_RUN, 0);
    cnt_chk("miss");

    // reset during DSTALL cycle 2
    miss = 1;
    step("miss_r0", E_MISS, 1);
    miss = 0;
    step("miss_r1", E_MISS, 1);
    do_reset();
    step("rst_run", E_RUN, 0);
    cnt_chk("rst_run");

    // plain halt: DRAIN for three cycles, MEMWBHLT on the third
    hlt = 1;
    step("hlt", E_FL, 1);
    hlt = 0; br = 1; ims = 1;
    step("drain1", E_FL, 0);
    br = 0; ims = 0;
    step("drain2", E_FL, 0);
    mwhlt = 1;
    step("drain3", E_FL, 0);
    mwhlt = 0; br = 1; miss = 1;
    step("halted0", E_HALT, 0);
    step("halted1", E_HALT, 0);
    clr();
    cnt_chk("halt");

    // miss during drain returns to DRAIN
    do_reset();
    hlt = 1;
    step("hlt2", E_FL, 1);
    hlt = 0; miss = 1;
    step("drain_miss", E_MISS, 0);
    miss = 0;
    for (int i = 0; i < 3; i++) step("drain_dstall", E_MISS, 1);
    step("drain_back", E_FL, 0);
    mwhlt = 1;
    step("drain_end", E_FL, 0);
    clr();
    step("halted2", E_HALT, 0);
    cnt_chk("drain_miss");

    // saturation on the 4-bit instance
    do_reset();
    chk("sat_rst", {24'd0, s_cyc, s_stall}, 32'd0);
    ims = 1;
    for (int i = 0; i < 20; i++) step("sat_ims", E_FL, 1);
    clr();
    chk("sat_stall", {28'd0, s_stall}, 32'd15);
    chk("sat_cyc", {28'd0, s_cyc}, 32'd15);
    cnt_chk("sat_wide");

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
